depth_sprite_scaler: RTL and testbench

Parametrised successor to the per-zone ball sprite renderer. Uses one base sprite ROM of SPR_DIM x SPR_DIM texels and scales it by depth zone using fixed-point nearest-neighbour column and row accumulators, so no per-zone ROMs are needed. Sits between the VGA scan timing and the pixel compositor. Sprite position is latched once per frame (no tearing), the pipeline has a fixed 2-cycle latency, and the block outputs colour plus a transparency flag.

---
 rtl/depth_sprite_scaler_if.sv | 32 +++
 rtl/depth_sprite_scaler.sv | 104 ++++++++++
 tb/tb_depth_sprite_scaler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/depth_sprite_scaler_if.sv
// depth_sprite_scaler_if: scan, ROM and colour signals between the VGA timing side and the sprite scaler.
interface depth_sprite_scaler_if #(
  parameter int W_COORD   = 16,
  parameter int COLOR_W   = 3,
  parameter int SPR_DIM   = 64,
  parameter int NUM_ZONES = 8
);
  logic frame_start;
  logic [W_COORD-1:0] x_loc, y_loc, z_loc, pixel_x, pixel_y;
  logic pixel_valid;
  logic [2*$clog2(SPR_DIM)-1:0] rom_addr;
  logic [COLOR_W-1:0] rom_data, color;
  logic opaque, color_valid;
  logic [$clog2(NUM_ZONES)-1:0] zone;
`ifdef SPRITE_MIRROR_EN
  logic mirror_x;
`endif
  modport slave (
    input frame_start, x_loc, y_loc, z_loc, pixel_x, pixel_y, pixel_valid, rom_data,
`ifdef SPRITE_MIRROR_EN
    input mirror_x,
`endif
    output rom_addr, color, opaque, color_valid, zone
  );
  modport master (
    output frame_start, x_loc, y_loc, z_loc, pixel_x, pixel_y, pixel_valid, rom_data,
`ifdef SPRITE_MIRROR_EN
    output mirror_x,
`endif
    input rom_addr, color, opaque, color_valid, zone
  );
endinterface

// File: rtl/depth_sprite_scaler.sv
// depth_sprite_scaler: depth-zoned nearest-neighbour scaling of one base sprite ROM, 2-cycle pixel latency.
// Define SPRITE_MIRROR_EN to add a per-frame horizontal mirror input (mirror_x).
module depth_sprite_scaler #(
  parameter int W_COORD     = 16,
  parameter int SPR_DIM     = 64,
  parameter int MAX_SIZE    = 64,
  parameter int SIZE_STEP   = 6,
  parameter int NUM_ZONES   = 8,
  parameter int ZONE_DEPTH  = 100,
  parameter int FRAC        = 8,
  parameter int COLOR_W     = 3,
  parameter int TRANSPARENT = 0
) (
  input logic clk,
  input logic rst,
  depth_sprite_scaler_if.slave bus
);
  localparam int LD = $clog2(SPR_DIM);
  localparam int ZW = $clog2(NUM_ZONES);
  localparam int ACC_W = LD + FRAC;
  localparam int SW = ACC_W + 1;
  localparam int CW = W_COORD + 1;
  logic [W_COORD-1:0] x_lat, y_lat, py_prev, zq;
  logic [ZW-1:0] zone_q;
  logic [ACC_W-1:0] col_prev, row_acc, col_cur, row_cur;
  logic [SW-1:0] step, col_sum, row_sum;
  logic [SW-1:0] step_tab [NUM_ZONES];
  logic [CW-1:0] size_tab [NUM_ZONES];
  logic [CW-1:0] size, x_hi, y_hi;
  logic act_x, act_y, active, hit, v1, a1;
  logic [LD-1:0] src_col;
  logic [2*LD-1:0] addr_c, addr_q;
`ifdef SPRITE_MIRROR_EN
  logic mir;
`endif
  // Per-zone edge and texel step are elaboration-time constants; no per-zone ROMs.
  for (genvar i = 0; i < NUM_ZONES; i++) begin : g_tab
    assign step_tab[i] = SW'((SPR_DIM << FRAC) / (MAX_SIZE - i * SIZE_STEP));
    assign size_tab[i] = CW'(MAX_SIZE - i * SIZE_STEP);
  end
  assign zq = bus.z_loc / W_COORD'(ZONE_DEPTH);
  assign step = step_tab[zone_q];
  assign size = size_tab[zone_q];
  assign x_hi = {1'b0, x_lat} + size - CW'(1);
  assign y_hi = {1'b0, y_lat} + size - CW'(1);
  assign bus.zone = zone_q;
  always_comb begin
    act_x = bus.pixel_x >= x_lat && {1'b0, bus.pixel_x} <= x_hi;
    act_y = bus.pixel_y >= y_lat && {1'b0, bus.pixel_y} <= y_hi;
    active = act_x && act_y;
    hit = bus.pixel_valid && active;
    col_sum = {1'b0, col_prev} + step;
    row_sum = {1'b0, row_acc} + step;
    col_cur = bus.pixel_x == x_lat ? '0 : active ? col_sum[ACC_W-1:0] : col_prev;
    row_cur = bus.pixel_y == py_prev ? row_acc : bus.pixel_y == y_lat ? '0 : act_y ? row_sum[ACC_W-1:0] : row_acc;
`ifdef SPRITE_MIRROR_EN
    src_col = mir ? ~col_cur[ACC_W-1:FRAC] : col_cur[ACC_W-1:FRAC];
`else
    src_col = col_cur[ACC_W-1:FRAC];
`endif
    addr_c = {row_cur[ACC_W-1:FRAC], src_col};
    bus.rom_addr = hit && !rst ? addr_c : addr_q;
  end
  // The address is presented combinationally so the synchronous ROM returns data one cycle later.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_lat <= '0;
      y_lat <= '0;
      zone_q <= '0;
      col_prev <= '0;
      row_acc <= '0;
      py_prev <= '0;
      addr_q <= '0;
      v1 <= 1'b0;
      a1 <= 1'b0;
      bus.color_valid <= 1'b0;
      bus.opaque <= 1'b0;
      bus.color <= '0;
`ifdef SPRITE_MIRROR_EN
      mir <= 1'b0;
`endif
    end else begin
      if (bus.frame_start) begin
        x_lat <= bus.x_loc;
        y_lat <= bus.y_loc;
        zone_q <= zq > W_COORD'(NUM_ZONES - 1) ? ZW'(NUM_ZONES - 1) : zq[ZW-1:0];
        col_prev <= '0;
        row_acc <= '0;
`ifdef SPRITE_MIRROR_EN
        mir <= bus.mirror_x;
`endif
      end else if (bus.pixel_valid) begin
        col_prev <= col_cur;
        row_acc <= row_cur;
      end
      if (bus.pixel_valid) py_prev <= bus.pixel_y;
      if (hit) addr_q <= addr_c;
      v1 <= bus.pixel_valid;
      a1 <= hit;
      bus.color_valid <= v1;
      bus.opaque <= a1 && bus.rom_data != COLOR_W'(TRANSPARENT);
      bus.color <= a1 && bus.rom_data != COLOR_W'(TRANSPARENT) ? bus.rom_data : '0;
    end
endmodule

// File: tb/tb_depth_sprite_scaler.sv
// tb_depth_sprite_scaler: table vectors, corner sequences and random frame scans against a closed-form model.
module tb_depth_sprite_scaler;
  typedef struct {int x, y, z, px, py, addr, zone, col;} vec_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  depth_sprite_scaler_if bus ();
  depth_sprite_scaler dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  int mx = 0, my = 0, mz = 0;
  int last_addr;
  bit hv1 = 0, hv2 = 0, act;
  int ho1 = 0, ho2 = 0, hc1 = 0, hc2 = 0, ea, eo, ec, cpx, cpy;

  function automatic int zone_of(int z); return z / 100 > 7 ? 7 : z / 100; endfunction
  function automatic int size_of(int z); return 64 - 6 * zone_of(z); endfunction
  function automatic int step_of(int z); return (64 * 256) / size_of(z); endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Synchronous texel ROM: texel value is the low 3 address bits.
  always @(posedge clk) bus.rom_data <= bus.rom_addr[2:0];

  always @(posedge clk or posedge rst)
    if (rst) begin
      mx <= 0; my <= 0; mz <= 0;
    end else if (bus.frame_start) begin
      mx <= int'(bus.x_loc); my <= int'(bus.y_loc); mz <= int'(bus.z_loc);
    end

  // Source texel is the pixel offset times the step, truncated; outputs trail inputs by two cycles.
  always @(negedge clk)
    if (rst) begin
      hv1 = 0; hv2 = 0; ho1 = 0; ho2 = 0; hc1 = 0; hc2 = 0;
    end else begin
      cpx = int'(bus.pixel_x);
      cpy = int'(bus.pixel_y);
      act = bus.pixel_valid && cpx >= mx && cpx <= mx + size_of(mz) - 1 && cpy >= my && cpy <= my + size_of(mz) - 1;
      ea = (((cpy - my) * step_of(mz)) >> 8) * 64 + (((cpx - mx) * step_of(mz)) >> 8);
      if (act) chk("rom_addr", int'(bus.rom_addr), ea);
      eo = (act && ea % 8 != 0) ? 1 : 0;
      ec = eo ? ea % 8 : 0;
      chk("color_valid", int'(bus.color_valid), int'(hv2));
      if (hv2) begin
        chk("opaque", int'(bus.opaque), ho2);
        chk("color", int'(bus.color), hc2);
      end
      chk("zone", int'(bus.zone), zone_of(mz));
      hv2 = hv1; ho2 = ho1; hc2 = hc1;
      hv1 = bus.pixel_valid; ho1 = eo; hc1 = ec;
    end

  task automatic frame(int x, int y, int z);
    @(posedge clk); #1;
    bus.frame_start = 1; bus.pixel_valid = 0;
    bus.x_loc = 16'(x); bus.y_loc = 16'(y); bus.z_loc = 16'(z);
    @(posedge clk); #1;
    bus.frame_start = 0;
  endtask

  task automatic pix(int x, int y);
    if ($urandom_range(7) == 0) begin
      @(posedge clk); #1;
      bus.pixel_valid = 0;
    end
    @(posedge clk); #1;
    bus.pixel_valid = 1; bus.pixel_x = 16'(x); bus.pixel_y = 16'(y);
    @(negedge clk);
    last_addr = int'(bus.rom_addr);
  endtask

  task automatic run_vec(vec_t v);
    frame(v.x, v.y, v.z);
    for (int y = v.y; y <= v.py; y++)
      for (int x = v.x - 1; x <= (y == v.py ? v.px : v.x + size_of(v.z)); x++) pix(x, y);
    chk("vec_addr", last_addr, v.addr);
    chk("vec_zone", int'(bus.zone), v.zone);
    @(posedge clk); #1;
    bus.pixel_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("vec_opaque", int'(bus.opaque), v.col != 0 ? 1 : 0);
    chk("vec_color", int'(bus.color), v.col);
  endtask

  initial begin
    vec_t tbl [9];
    int x, y, z;
    tbl[0] = '{100, 50, 50, 100, 50, 0, 0, 0};
    tbl[1] = '{100, 50, 50, 163, 50, 63, 0, 7};
    tbl[2] = '{100, 50, 50, 164, 50, 63, 0, 0};
    tbl[3] = '{100, 50, 50, 100, 113, 4032, 0, 0};
    tbl[4] = '{200, 10, 750, 221, 10, 61, 7, 5};
    tbl[5] = '{200, 10, 750, 222, 10, 61, 7, 0};
    tbl[6] = '{200, 10, 5000, 221, 10, 61, 7, 5};
    tbl[7] = '{200, 10, 5000, 221, 31, 3965, 7, 5};
    tbl[8] = '{200, 10, 750, 221, 32, 3965, 7, 0};
    bus.frame_start = 0; bus.pixel_valid = 0;
    bus.x_loc = 0; bus.y_loc = 0; bus.z_loc = 0; bus.pixel_x = 0; bus.pixel_y = 0;
`ifdef SPRITE_MIRROR_EN
    bus.mirror_x = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_color", int'(bus.color), 0);
    chk("rst_opaque", int'(bus.opaque), 0);
    chk("rst_color_valid", int'(bus.color_valid), 0);
    chk("rst_zone", int'(bus.zone), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    @(posedge clk); #1;
    rst = 0;
    foreach (tbl[i]) run_vec(tbl[i]);
    // New position latched in the same cycle as a pixel: that pixel keeps the old origin.
    frame(100, 50, 50);
    pix(99, 50); pix(100, 50); pix(101, 50);
    @(posedge clk); #1;
    bus.frame_start = 1; bus.x_loc = 300; bus.pixel_x = 100;
    @(negedge clk);
    chk("same_cycle_old_x", int'(bus.rom_addr), 0);
    @(posedge clk); #1;
    bus.frame_start = 0; bus.pixel_x = 300;
    @(negedge clk);
    chk("new_x_col0", int'(bus.rom_addr), 0);
    pix(301, 50);
    chk("new_x_col1", last_addr, 1);
    // Asynchronous reset in the middle of a streaming line.
    frame(200, 10, 750);
    pix(199, 10); pix(200, 10); pix(201, 10); pix(202, 10);
    #1 rst = 1;
    #1;
    chk("mid_rst_color_valid", int'(bus.color_valid), 0);
    chk("mid_rst_opaque", int'(bus.opaque), 0);
    chk("mid_rst_color", int'(bus.color), 0);
    chk("mid_rst_zone", int'(bus.zone), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0; bus.pixel_valid = 0;
    @(posedge clk); #1;
    bus.pixel_valid = 1; bus.pixel_x = 0; bus.pixel_y = 0;
    @(posedge clk); #1;
    bus.pixel_valid = 0;
    @(negedge clk);
    chk("post_rst_cycle1_valid", int'(bus.color_valid), 0);
    @(negedge clk);
    chk("post_rst_cycle2_valid", int'(bus.color_valid), 1);
    @(negedge clk);
    chk("post_rst_cycle3_valid", int'(bus.color_valid), 0);
    // Random full-region frame scans including the border pixels.
    for (int f = 0; f < 4; f++) begin
      x = int'($urandom_range(200, 2));
      y = int'($urandom_range(100, 2));
      z = f == 3 ? int'($urandom_range(65535, 800)) : int'($urandom_range(900, 0));
      frame(x, y, z);
      for (int yy = y - 1; yy <= y + size_of(z); yy++)
        for (int xx = x - 2; xx <= x + size_of(z) + 1; xx++) pix(xx, yy);
    end
    @(posedge clk); #1;
    bus.pixel_valid = 0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
